// File: rtl/plate_pkg.sv
// Shared types and constants for the plate (paddle) motion controller.
package plate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } plate_state_t;

  localparam logic [7:0] PLATE_TOP   = 8'hE0;
  localparam logic [7:0] PLATE_BOT   = 8'h07;
  localparam logic [7:0] PLATE_RESET = 8'h38;

  // A step toward an edge the paddle already touches is swallowed.
  function automatic logic step_blocked(input logic up, input logic [7:0] pos);
    return up ? (pos == PLATE_TOP) : (pos == PLATE_BOT);
  endfunction

endpackage

// File: rtl/plate_move_fsm.sv
// One player's button synchroniser, request decode, press/hold/repeat FSM
// and edge-limit suppression.
module plate_move_fsm
  import plate_pkg::*;
#(
  parameter int HOLD_TICKS   = 3,
  parameter int REPEAT_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       freeze,
  input  logic       tick,
  input  logic [7:0] pos,
  output logic       dir,
  output logic       move
);

  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HOLD   = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_REPEAT = CNT_W'(REPEAT_TICKS);

  logic [1:0]       up_sync;
  logic [1:0]       dn_sync;
  logic             req_up;
  logic             req_dn;
  logic             req_valid;
  plate_state_t     state;
  plate_state_t     state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             dir_n;
  logic             move_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_dn};
    end
  end

  // Pressing both buttons cancels out to no request.
  assign req_up    = up_sync[1] & ~dn_sync[1];
  assign req_dn    = dn_sync[1] & ~up_sync[1];
  assign req_valid = req_up | req_dn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
      move  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir   <= dir_n;
      move  <= move_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir;
    move_n  = 1'b0;
    if (freeze) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // First step is issued at once, not aligned to the tick.
          if (req_valid) begin
            state_n = HOLD;
            dir_n   = req_up;
            cnt_n   = CNT_HOLD;
            move_n  = ~step_blocked(req_up, pos);
          end
        end
        HOLD, REPEAT: begin
          if (!req_valid || (req_up != dir)) begin
            state_n = IDLE;
          end else if (tick) begin
            if (cnt == CNT_ONE) begin
              state_n = REPEAT;
              cnt_n   = CNT_REPEAT;
              move_n  = ~step_blocked(dir, pos);
            end else begin
              cnt_n = cnt - CNT_ONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/plate_move_ctrl.sv
// Two-player plate motion controller: shared step divider plus one move FSM
// per player. Define PLATE_AI_EN to drive the right player from ball_row.
module plate_move_ctrl
  import plate_pkg::*;
#(
  parameter int TICK_DIV     = 2500000,
  parameter int HOLD_TICKS   = 3,
  parameter int REPEAT_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       freeze,
  input  logic [7:0] left_pos,
  input  logic [7:0] right_pos,
  input  logic [7:0] ball_row,
  output logic       l_dir,
  output logic       l_move,
  output logic       r_dir,
  output logic       r_move,
  output logic       step_tick
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             r_up_src;
  logic             r_dn_src;

  // Free-running divider; freeze deliberately does not touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div       <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= (div == DIV_LAST);
      div       <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

`ifdef PLATE_AI_EN
  // Chase the ball: bitmaps compare as integers, higher value means higher row.
  logic btn_r_unused;
  assign btn_r_unused = btn_r_up ^ btn_r_dn;
  assign r_up_src = (ball_row > right_pos);
  assign r_dn_src = ((ball_row & right_pos) == 8'h00) && (ball_row < right_pos) &&
                    (ball_row != 8'h00);
`else
  logic ball_row_unused;
  assign ball_row_unused = ^ball_row;
  assign r_up_src = btn_r_up;
  assign r_dn_src = btn_r_dn;
`endif

  plate_move_fsm #(
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_left (
    .clk   (clk),
    .reset (reset),
    .btn_up(btn_l_up),
    .btn_dn(btn_l_dn),
    .freeze(freeze),
    .tick  (step_tick),
    .pos   (left_pos),
    .dir   (l_dir),
    .move  (l_move)
  );

  plate_move_fsm #(
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_right (
    .clk   (clk),
    .reset (reset),
    .btn_up(r_up_src),
    .btn_dn(r_dn_src),
    .freeze(freeze),
    .tick  (step_tick),
    .pos   (right_pos),
    .dir   (r_dir),
    .move  (r_move)
  );

endmodule

// File: tb/tb_plate_move_ctrl.sv
// Self-checking bench for plate_move_ctrl against a press/hold/repeat model.
module tb_plate_move_ctrl;
  import plate_pkg::*;

  localparam int TICK_DIV     = 4;
  localparam int HOLD_TICKS   = 2;
  localparam int REPEAT_TICKS = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] left_pos = PLATE_RESET, right_pos = PLATE_RESET, ball_row = 8'h00;
  logic       l_dir, l_move, r_dir, r_move, step_tick;

  int total = 0;
  int bad = 0;

  plate_move_ctrl #(
    .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .freeze(freeze), .left_pos(left_pos), .right_pos(right_pos), .ball_row(ball_row),
    .l_dir(l_dir), .l_move(l_move), .r_dir(r_dir), .r_move(r_move), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  // Player model: a press steps at once, then waits HOLD ticks, then every REPEAT ticks.
  typedef struct {
    logic d1u, d1d, d2u, d2d;
    logic active, dir, move;
    int   ticks, need;
  } pm_t;

  pm_t  ml, mr;
  logic m_tick;
  int   cyc;

  function automatic pm_t pm_clear();
    pm_t p;
    p.d1u = 0; p.d1d = 0; p.d2u = 0; p.d2d = 0;
    p.active = 0; p.dir = 0; p.move = 0; p.ticks = 0; p.need = 0;
    return p;
  endfunction

  function automatic logic at_edge(input logic up, input logic [7:0] pos);
    return up ? (pos == 8'hE0) : (pos == 8'h07);
  endfunction

  function automatic void model_player(inout pm_t p, input logic bu, input logic bd,
                                       input logic frz, input logic tk, input logic [7:0] pos);
    logic up, dn;
    up = p.d2u & ~p.d2d;
    dn = p.d2d & ~p.d2u;
    p.d2u = p.d1u; p.d2d = p.d1d; p.d1u = bu; p.d1d = bd;
    p.move = 0;
    if (frz) p.active = 0;
    else if (!p.active) begin
      if (up || dn) begin
        p.active = 1; p.dir = up; p.ticks = 0; p.need = HOLD_TICKS;
        p.move = !at_edge(up, pos);
      end
    end else if (!(up || dn) || (up != p.dir)) p.active = 0;
    else if (tk) begin
      p.ticks++;
      if (p.ticks >= p.need) begin
        p.ticks = 0; p.need = REPEAT_TICKS;
        p.move = !at_edge(p.dir, pos);
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    logic tk, ru, rd;
    if (!reset) begin
      ml = pm_clear(); mr = pm_clear(); m_tick = 0; cyc = 0;
    end else begin
      tk = m_tick;
      cyc++;
      m_tick = (cyc % TICK_DIV == 0);
`ifdef PLATE_AI_EN
      ru = (ball_row > right_pos);
      rd = ((ball_row & right_pos) == 8'h00) && (ball_row < right_pos) && (ball_row != 8'h00);
`else
      ru = btn_r_up;
      rd = btn_r_dn;
`endif
      model_player(ml, btn_l_up, btn_l_dn, freeze, tk, left_pos);
      model_player(mr, ru, rd, freeze, tk, right_pos);
    end
  end

  function automatic logic [4:0] dut_vec();
    return {l_dir, l_move, r_dir, r_move, step_tick};
  endfunction

  function automatic logic [4:0] exp_vec();
    return {ml.dir, ml.move, mr.dir, mr.move, m_tick};
  endfunction

  task automatic applyStimulus(input logic lu, input logic ld, input logic ru,
                               input logic rd, input logic frz);
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd; freeze = frz;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== 5'b0) begin
        bad++; $display("[TB] FAIL reset_state: got %b want 00000", dut_vec());
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_single_pulse();
    int strobes = 0, first = -1;
    logic dir_at = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL pulse_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (l_move) begin
        strobes++;
        if (first < 0) begin first = i; dir_at = l_dir; end
      end
      if (i == 1) applyStimulus(0, 0, 0, 0, 0);
    end
    total++;
    if (strobes !== 1) begin bad++; $display("[TB] FAIL pulse_count: got %0d want 1", strobes); end
    total++;
    if (first !== 3) begin bad++; $display("[TB] FAIL pulse_latency: got %0d want 3", first); end
    total++;
    if (dir_at !== 1'b1) begin bad++; $display("[TB] FAIL pulse_dir: got %b want 1", dir_at); end
  endtask

  task automatic test_hold_repeat();
    int idx[$];
    int dir_bad = 0;
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL hold_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (l_move) idx.push_back(i);
      if (i >= 3 && l_dir !== 1'b0) dir_bad++;
    end
    applyStimulus(0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    total++;
    if (idx.size() < 3) begin
      bad++; $display("[TB] FAIL hold_strobes: got %0d want >=3", idx.size());
    end else begin
      total++;
      if (idx[0] !== 3) begin bad++; $display("[TB] FAIL hold_first: got %0d want 3", idx[0]); end
      total++;
      if (idx[1] - idx[0] <= TICK_DIV || idx[1] - idx[0] > 2 * TICK_DIV) begin
        bad++; $display("[TB] FAIL hold_gap: got %0d want 5..8", idx[1] - idx[0]);
      end
      total++;
      if (idx[2] - idx[1] !== TICK_DIV) begin
        bad++; $display("[TB] FAIL repeat_gap: got %0d want %0d", idx[2] - idx[1], TICK_DIV);
      end
    end
    total++;
    if (dir_bad !== 0) begin bad++; $display("[TB] FAIL hold_dir: got %0d bad cycles want 0", dir_bad); end
  endtask

  task automatic test_edge_limit();
    int lm = 0, rm = 0;
    left_pos = 8'h07; right_pos = 8'hE0;
    applyStimulus(0, 1, 1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL edge_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      lm += int'(l_move);
      rm += int'(r_move);
    end
    total++;
    if (lm !== 0) begin bad++; $display("[TB] FAIL edge_bottom: got %0d strobes want 0", lm); end
    total++;
    if (l_dir !== 1'b0) begin bad++; $display("[TB] FAIL edge_ldir: got %b want 0", l_dir); end
`ifndef PLATE_AI_EN
    total++;
    if (rm !== 0) begin bad++; $display("[TB] FAIL edge_top: got %0d strobes want 0", rm); end
    total++;
    if (r_dir !== 1'b1) begin bad++; $display("[TB] FAIL edge_rdir: got %b want 1", r_dir); end
`endif
    applyStimulus(0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    left_pos = PLATE_RESET; right_pos = PLATE_RESET;
  endtask

  task automatic test_both_buttons();
    int lm = 0, first = -1;
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL both_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      lm += int'(l_move);
    end
    total++;
    if (lm !== 0) begin bad++; $display("[TB] FAIL both_nomove: got %0d want 0", lm); end
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (l_move && first < 0 && l_dir === 1'b1) first = i;
    end
    total++;
    if (first < 1) begin bad++; $display("[TB] FAIL both_release: got none want up step within 3"); end
    applyStimulus(0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_freeze();
    int fm = 0;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL prefreeze_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      fm += int'(l_move);
    end
    total++;
    if (fm !== 0) begin bad++; $display("[TB] FAIL freeze_hold: got %0d strobes want 0", fm); end
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (l_move !== 1'b1) begin bad++; $display("[TB] FAIL freeze_release: got %b want 1", l_move); end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL postfreeze_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    applyStimulus(0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int early = 0;
    applyStimulus(1, 0, 1, 0, 0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 5'b0) begin bad++; $display("[TB] FAIL midop_reset: got %b want 00000", dut_vec()); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL midop_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (i <= 2) early += int'(l_move | r_move);
    end
    total++;
    if (early !== 0) begin bad++; $display("[TB] FAIL midop_early: got %0d want 0", early); end
    applyStimulus(0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] pos_tab [4];
    logic lu = 0, ld = 0, ru = 0, rd = 0, frz = 0;
    pos_tab[0] = 8'h38; pos_tab[1] = 8'hE0; pos_tab[2] = 8'h07; pos_tab[3] = 8'h1C;
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("[TB] FAIL random_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if ($urandom_range(5) == 0) lu = ~lu;
      if ($urandom_range(5) == 0) ld = ~ld;
      if ($urandom_range(5) == 0) ru = ~ru;
      if ($urandom_range(5) == 0) rd = ~rd;
      frz = ($urandom_range(19) == 0) ? ~frz : frz;
      if ($urandom_range(7) == 0) left_pos = pos_tab[$urandom_range(3)];
      if ($urandom_range(7) == 0) right_pos = pos_tab[$urandom_range(3)];
      ball_row = 8'h01 << $urandom_range(7);
      applyStimulus(lu, ld, ru, rd, frz);
    end
    applyStimulus(0, 0, 0, 0, 0);
    ball_row = 8'h00; left_pos = PLATE_RESET; right_pos = PLATE_RESET;
    repeat (8) @(negedge clk);
  endtask

`ifdef PLATE_AI_EN
  task automatic test_ai();
    logic [7:0] rows [3];
    int counts [3];
    logic dirs [3];
    rows[0] = 8'h80; rows[1] = 8'h10; rows[2] = 8'h02;
    right_pos = 8'h38;
    for (int k = 0; k < 3; k++) begin
      ball_row = rows[k];
      counts[k] = 0;
      for (int i = 1; i <= 24; i++) begin
        @(negedge clk);
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++; $display("[TB] FAIL ai_cycle %0d/%0d: got %b want %b", k, i, dut_vec(), exp_vec());
        end
        if (i > 4) counts[k] += int'(r_move);
      end
      dirs[k] = r_dir;
    end
    total++;
    if (counts[0] < 1 || dirs[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL ai_up: got %0d strobes dir %b want >0 dir 1", counts[0], dirs[0]);
    end
    total++;
    if (counts[1] !== 0) begin bad++; $display("[TB] FAIL ai_aligned: got %0d want 0", counts[1]); end
    total++;
    if (counts[2] < 1 || dirs[2] !== 1'b0) begin
      bad++; $display("[TB] FAIL ai_down: got %0d strobes dir %b want >0 dir 0", counts[2], dirs[2]);
    end
    ball_row = 8'h00; right_pos = PLATE_RESET;
    repeat (8) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_pulse();
    test_hold_repeat();
    test_edge_limit();
    test_both_buttons();
    test_freeze();
    test_reset_midop();
`ifdef PLATE_AI_EN
    test_ai();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plate_move_ctrl.md
Name: plate_move_ctrl

Overview:
- Per-player motion controller in front of the plate (paddle) datapath.
- Converts raw up/down buttons into the plate's direction level and move strobe (sw1/sw2, sw3/sw4).
- Features: input synchronisation, a rate-limited step tick, hold-to-repeat, freeze from the game FSM, and edge-limit suppression.
- Sits between the board buttons and the plate register block; plate position feedback comes back from that block.

Parameters:
- TICK_DIV, 2500000, clk cycles per step tick (must be ≥2).
- HOLD_TICKS, 3, ticks a button must stay held after the first step before auto-repeat starts (≥1).
- REPEAT_TICKS, 1, ticks between auto-repeat steps (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_l_up  in  1  left player up, raw/asynchronous
- btn_l_dn  in  1  left player down, raw/asynchronous
- btn_r_up  in  1  right player up, raw/asynchronous
- btn_r_dn  in  1  right player down, raw/asynchronous
- freeze  in  1  game FSM holds paddles (serve/score); synchronous
- left_pos  in  8  current left paddle bitmap (3 contiguous ones)
- right_pos  in  8  current right paddle bitmap
- ball_row  in  8  one-hot ball row; used only with PLATE_AI_EN
- l_dir  out  1  left direction, 1 = up (shift left)
- l_move  out  1  left move strobe, one cycle
- r_dir  out  1  right direction, 1 = up
- r_move  out  1  right move strobe, one cycle
- step_tick  out  1  divider tick, one cycle (debug/shared)

Behaviour:
- All outputs registered. Reset values: l_dir=0, l_move=0, r_dir=0, r_move=0, step_tick=0. FSMs go to IDLE, divider=0, sync flops=0.
- Buttons: 2-flop synchroniser each.
- Request per player:
  - up = synced_up & ~synced_dn
  - dn = synced_dn & ~synced_up
  - both or neither asserted = no request.
- Divider counts 0..TICK_DIV-1 and wraps. step_tick=1 in the cycle after the count reaches TICK_DIV-1. Divider runs freely, unaffected by freeze.
- Per-player FSM states: IDLE, HOLD, REPEAT. cnt is a tick down-counter.
  - IDLE → HOLD on a valid request:
    - issue a step immediately (not tick-aligned)
    - dir <= up
    - cnt <= HOLD_TICKS
  - HOLD:
    - on each step_tick, cnt decrements
    - on a step_tick with cnt==1: issue a step, cnt <= REPEAT_TICKS, go to REPEAT
  - REPEAT:
    - on each step_tick, cnt decrements
    - at cnt==1: issue a step and reload REPEAT_TICKS
  - HOLD/REPEAT → IDLE when the request drops or its direction differs from the latched dir. No step that cycle; a new request is accepted from IDLE on the next cycle.
- Step issue: move=1 for exactly one cycle, dir valid in the same cycle, dir held afterwards.
- Edge-limit suppression:
  - an up step is suppressed when pos==8'hE0
  - a down step is suppressed when pos==8'h07
  - the FSM still advances.
- freeze=1: FSMs forced to IDLE, move=0. Buttons held through freeze release act as a fresh press on the first cycle after freeze falls.
- Latency: button edge → move strobe = 3 clk (2 sync + 1 FSM register).
- Reset asserted mid-operation: outputs cleared immediately (async). Strobes resume only after a fresh request following deassertion.
- Left and right FSMs are fully independent; simultaneous strobes are allowed.

Optional Feature:
- PLATE_AI_EN defined: the right-player request is generated from ball_row and right_pos, and btn_r_* are ignored.
  - up = (ball_row > right_pos)
  - dn = ((ball_row & right_pos)==0) && (ball_row < right_pos) && (ball_row != 0)
  - The AI request feeds the same FSM, so repeat pacing still applies.
- Not defined: ball_row is unused, and the right player uses the buttons.

Decomposition:
- Shared package plate_pkg:
  - FSM state enum {IDLE, HOLD, REPEAT}
  - PLATE_TOP=8'hE0, PLATE_BOT=8'h07, PLATE_RESET=8'h38
- Sub-module plate_move_fsm:
  - one player's synchroniser, request decode, FSM, limit suppression
  - instantiated twice
- Divider and AI request logic live in the top module.

Test Plan (TICK_DIV=4, HOLD_TICKS=2, REPEAT_TICKS=1):
- Reset, then pulse btn_l_up for 1 cycle with left_pos=8'h38 → exactly one l_move, 3 clk after the edge, l_dir=1. No further strobes.
- Hold btn_l_dn for 40 cycles → first strobe at +3 clk, next on the 2nd following step_tick, then one per step_tick. l_dir=0 throughout.
- Hold btn_r_up with right_pos=8'hE0 → r_move never asserts. FSM visits HOLD/REPEAT and r_dir=1.
- Assert both btn_l_up and btn_l_dn → no l_move. Release dn → fresh step with l_dir=1 within 3 clk.
- Assert freeze while btn_l_up is held in REPEAT → strobes stop next cycle. Deassert freeze → immediate step, then HOLD spacing.
- With PLATE_AI_EN: right_pos=8'h38, ball_row=8'h80 → r_dir=1 strobes. ball_row=8'h10 → none. ball_row=8'h02 → r_dir=0 strobes.
